// File: rtl/mult_arbiter.sv
// ============================================================================
// Module   : mult_arbiter (with internal sub-module mult)
// Purpose  : Round-robin arbiter that shares one 6-stage pipelined
//            single-precision float multiplier among N_REQ requesters.
//            A tag shadow pipeline tracks which requester owns each product.
// Options  : MULT_ARB_PERF_EN adds grant_cnt / busy_cnt performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arbiter_pkg;
    // IEEE-754 single precision: {sign, exp[7:0], frac[22:0]}
    typedef logic [31:0] p_float;
endpackage

// ============================================================================
// Module   : mult
// Purpose  : 6-stage pipelined float multiplier. No valid, stall or reset:
//            callers track validity themselves. Denormals flush to zero,
//            round to nearest even, overflow saturates to infinity.
// Revision : 1.0 - initial release
// ============================================================================
module mult
    import mult_arbiter_pkg::*;
(
    input  logic   clk,
    input  p_float a,
    input  p_float b,
    output p_float p
);
    localparam int c_TAIL = 3;   // pure delay stages after packing

    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic              r1_sign, r1_zero, r1_inf, r1_nan;
    logic signed [9:0] r1_exp;
    logic [23:0]       r1_ma, r1_mb;
    logic              r2_sign, r2_zero, r2_inf, r2_nan;
    logic signed [9:0] r2_exp;
    logic [47:0]       r2_prod;
    logic              w_hi, w_guard, w_sticky, w_inc;
    logic [22:0]       w_mant;
    logic [23:0]       w_mant_r;
    logic signed [9:0] w_exp_n;
    p_float            w_pack;
    p_float            r3_pack;
    p_float            r_tail [c_TAIL];

    assign w_a_zero = (a[30:23] == 8'h00);
    assign w_b_zero = (b[30:23] == 8'h00);
    assign w_a_inf  = (a[30:23] == 8'hFF);
    assign w_b_inf  = (b[30:23] == 8'hFF);
    assign w_a_nan  = w_a_inf & (|a[22:0]);
    assign w_b_nan  = w_b_inf & (|b[22:0]);

    // Stage 1: unpack operands, classify specials, add biased exponents
    always_ff @(posedge clk) begin
        r1_sign <= a[31] ^ b[31];
        r1_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
        r1_inf  <= w_a_inf | w_b_inf;
        r1_zero <= w_a_zero | w_b_zero;
        r1_exp  <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        r1_ma   <= {1'b1, a[22:0]};
        r1_mb   <= {1'b1, b[22:0]};
    end

    // Stage 2: full 24x24 mantissa product
    always_ff @(posedge clk) begin
        r2_sign <= r1_sign;
        r2_nan  <= r1_nan;
        r2_inf  <= r1_inf;
        r2_zero <= r1_zero;
        r2_exp  <= r1_exp;
        r2_prod <= r1_ma * r1_mb;
    end

    // Normalise by one bit if the product reached [2,4), then round nearest even
    assign w_hi     = r2_prod[47];
    assign w_mant   = w_hi ? r2_prod[46:24] : r2_prod[45:23];
    assign w_guard  = w_hi ? r2_prod[23]    : r2_prod[22];
    assign w_sticky = w_hi ? (|r2_prod[22:0]) : (|r2_prod[21:0]);
    assign w_inc    = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {23'b0, w_inc};
    assign w_exp_n  = r2_exp + (w_hi ? 10'sd1 : 10'sd0) + (w_mant_r[23] ? 10'sd1 : 10'sd0);

    // Pack result; specials take priority over the computed value
    always_comb begin
        w_pack = {r2_sign, w_exp_n[7:0], w_mant_r[22:0]};
        if (r2_nan) begin
            w_pack = 32'h7FC0_0000;
        end else if (r2_inf) begin
            w_pack = {r2_sign, 8'hFF, 23'b0};
        end else if (r2_zero) begin
            w_pack = {r2_sign, 31'b0};
        end else if (w_exp_n >= 10'sd255) begin
            w_pack = {r2_sign, 8'hFF, 23'b0};
        end else if (w_exp_n <= 10'sd0) begin
            w_pack = {r2_sign, 31'b0};
        end
    end

    // Stage 3 register plus delay stages 4..6
    always_ff @(posedge clk) begin
        r3_pack   <= w_pack;
        r_tail[0] <= r3_pack;
        for (int i = 1; i < c_TAIL; i++) begin
            r_tail[i] <= r_tail[i-1];
        end
    end

    assign p = r_tail[c_TAIL-1];
endmodule

// ============================================================================
// Module   : mult_arbiter
// Purpose  : Round-robin sharing of one mult instance, tagged result return,
//            enable/drain sequencing for upstream quiescing.
// Options  : MULT_ARB_PERF_EN - adds grant_cnt[] and busy_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 6,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(MULT_LAT + 2)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  p_float           req_a [N_REQ],
    input  p_float           req_b [N_REQ],
    output logic             res_valid,
    output logic [ID_W-1:0]  res_id,
    output p_float           res,
    output logic [CNT_W-1:0] in_flight,
    output logic             idle
`ifdef MULT_ARB_PERF_EN
    ,
    output logic [31:0]      grant_cnt [N_REQ],
    output logic [31:0]      busy_cnt
`endif
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [N_REQ-1:0] w_cand, w_gnt_oh;
    logic [ID_W-1:0]  w_gnt_idx, w_scan_idx;
    logic             w_gnt_any, w_xfer;
    int               w_scan;
    p_float           r_op_a, r_op_b, w_mult_p;
    logic [MULT_LAT:0] r_tag_vld;
    logic [ID_W-1:0]  r_tag_id [MULT_LAT+1];
    logic             w_tail_vld;
    logic [CNT_W-1:0] w_in_flight_nxt;

    // Only RUN with enable high may grant; IDLE must first step into RUN
    assign w_cand = (r_state == c_ST_RUN && enable) ? req_valid : '0;

    // Round-robin search starting just above the last granted index
    always_comb begin
        w_gnt_oh   = '0;
        w_gnt_idx  = '0;
        w_gnt_any  = 1'b0;
        w_scan     = 0;
        w_scan_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= N_REQ) begin
                w_scan = w_scan - N_REQ;
            end
            w_scan_idx = ID_W'(w_scan);
            if (!w_gnt_any && w_cand[w_scan_idx]) begin
                w_gnt_any             = 1'b1;
                w_gnt_idx             = w_scan_idx;
                w_gnt_oh[w_scan_idx]  = 1'b1;
            end
        end
    end

    assign req_ready  = w_gnt_oh;
    assign w_xfer     = w_gnt_any;
    assign w_tail_vld = r_tag_vld[MULT_LAT];

    // Operand stage feeding the multiplier; datapath needs no reset
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_op_a <= req_a[w_gnt_idx];
            r_op_b <= req_b[w_gnt_idx];
        end
    end

    mult u_mult (
        .clk (clk),
        .a   (r_op_a),
        .b   (r_op_b),
        .p   (w_mult_p)
    );

    // Tag shadow pipeline: stands in for the valid path mult lacks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i <= MULT_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_vld <= {r_tag_vld[MULT_LAT-1:0], w_xfer};
            r_tag_id[0] <= w_gnt_idx;
            for (int i = 1; i <= MULT_LAT; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Result register: product is masked to zero whenever no tag is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res       <= '0;
        end else begin
            res_valid <= w_tail_vld;
            res_id    <= r_tag_id[MULT_LAT];
            res       <= w_tail_vld ? w_mult_p : '0;
        end
    end

    // Occupancy: an op leaves the count on the edge its result is presented
    always_comb begin
        w_in_flight_nxt = in_flight;
        if (w_xfer && !w_tail_vld) begin
            w_in_flight_nxt = in_flight + 1'b1;
        end else if (!w_xfer && w_tail_vld) begin
            w_in_flight_nxt = in_flight - 1'b1;
        end
    end

    // Enable/drain sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!enable) w_state_nxt = (in_flight != '0) ? c_ST_DRAIN : c_ST_IDLE;
            end
            c_ST_DRAIN: begin
                if (enable)                w_state_nxt = c_ST_RUN;
                else if (in_flight == '0)  w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Control state, round-robin pointer, occupancy and idle flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_rr_ptr  <= ID_W'(N_REQ - 1);
            in_flight <= '0;
            idle      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            in_flight <= w_in_flight_nxt;
            idle      <= (w_state_nxt == c_ST_IDLE) && (w_in_flight_nxt == '0);
            if (w_xfer) begin
                r_rr_ptr <= w_gnt_idx;
            end
        end
    end

`ifdef MULT_ARB_PERF_EN
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_grant_cnt
            // Saturating transfer count for requester g
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_cnt[g] <= '0;
                end else if (w_gnt_oh[g] && (grant_cnt[g] != '1)) begin
                    grant_cnt[g] <= grant_cnt[g] + 32'd1;
                end
            end
        end
    endgenerate

    // Saturating count of cycles with work in the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if ((in_flight != '0) && (busy_cnt != '1)) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
// Module   : tb_mult_arbiter
// Purpose  : Directed, table-driven checks of mult_arbiter: reset, latency,
//            float products, round-robin order, drain and async reset.
//            Performance counters are checked when MULT_ARB_PERF_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arbiter;
    import mult_arbiter_pkg::*;

    localparam int N_REQ = 4;

    typedef struct {
        logic [1:0] idx;
        p_float     a;
        p_float     b;
        p_float     exp_p;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    p_float     req_a [N_REQ];
    p_float     req_b [N_REQ];
    logic       res_valid;
    logic [1:0] res_id;
    p_float     res;
    logic [2:0] in_flight;
    logic       idle;
`ifdef MULT_ARB_PERF_EN
    logic [31:0] grant_cnt [N_REQ];
    logic [31:0] busy_cnt;
`endif

    int         n_chk  = 0;
    int         n_fail = 0;
    vec_t       vecs [8];
    logic [1:0] q_id [$];
    p_float     q_val [$];

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(N_REQ), .MULT_LAT(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res       (res),
        .in_flight (in_flight),
        .idle      (idle)
`ifdef MULT_ARB_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .busy_cnt  (busy_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the first result, then check queued results back-to-back
    task automatic collect(input string name);
        int n = 0;
        while (!res_valid && n < 20) begin
            tick;
            n++;
        end
        while (q_id.size() > 0) begin
            chk({name, "_vld"}, {31'b0, res_valid}, 32'd1);
            chk({name, "_id"},  {30'b0, res_id},    {30'b0, q_id[0]});
            chk({name, "_res"}, res,                q_val[0]);
            void'(q_id.pop_front());
            void'(q_val.pop_front());
            tick;
        end
        chk({name, "_end"}, {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        int         n;
        int         cnt;
        int         last_at;
        int         first_idle;
        p_float     rr_a [4];
        p_float     rr_p [4];
        logic [3:0] alt  [4];

        vecs[0] = '{2'd1, 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000}; //  0.5 * 0.5
        vecs[1] = '{2'd2, 32'h4040_0000, 32'h4040_0000, 32'h4110_0000}; //  3 * 3
        vecs[2] = '{2'd3, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000}; //  0 * 5
        vecs[3] = '{2'd0, 32'hC000_0000, 32'hC040_0000, 32'h40C0_0000}; // -2 * -3
        vecs[4] = '{2'd1, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002}; // 1+ulp squared
        vecs[5] = '{2'd2, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000}; // overflow
        vecs[6] = '{2'd3, 32'hBFA0_0000, 32'h4080_0000, 32'hC0A0_0000}; // -1.25 * 4
        vecs[7] = '{2'd0, 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000}; // underflow

        rr_a = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        rr_p = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
        alt  = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = '0;
            req_b[i] = '0;
        end

        // ---- reset state ----
        tick;
        tick;
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_in_flight", {29'b0, in_flight}, 32'd0);
        chk("rst_idle",      {31'b0, idle},      32'd1);
        chk("rst_ready",     {28'b0, req_ready}, 32'd0);
        req_valid = 4'h0;
        rst_n     = 1'b1;
        tick;

        // ---- single op: 1.5 * 2.0 on requester 0, latency 7 ----
        enable    = 1'b1;
        req_valid = 4'b0001;
        req_a[0]  = 32'h3FC0_0000;
        req_b[0]  = 32'h4000_0000;
        #1;
        chk("first_ready_idle", {28'b0, req_ready}, 32'd0);
        tick;
        chk("first_ready_run", {28'b0, req_ready}, 32'd1);
        tick;
        req_valid = 4'h0;
        chk("first_in_flight", {29'b0, in_flight}, 32'd1);
        n = 0;
        while (!res_valid && n < 20) begin
            chk("first_hold_in_flight", {29'b0, in_flight}, 32'd1);
            tick;
            n++;
        end
        chk("first_latency",    n,                  32'd7);
        chk("first_res_id",     {30'b0, res_id},    32'd0);
        chk("first_res",        res,                32'h4040_0000);
        chk("first_in_flight0", {29'b0, in_flight}, 32'd0);
        tick;
        chk("first_res_masked", res,                32'd0);

        // ---- table of single-requester products ----
        for (int v = 0; v < 8; v++) begin
            req_valid            = 4'b0001 << vecs[v].idx;
            req_a[vecs[v].idx]   = vecs[v].a;
            req_b[vecs[v].idx]   = vecs[v].b;
            #1;
            chk("vec_ready", {28'b0, req_ready}, {28'b0, 4'b0001 << vecs[v].idx});
            tick;
            req_valid = 4'h0;
            n = 0;
            while (!res_valid && n < 20) begin
                tick;
                n++;
            end
            chk("vec_latency", n,               32'd7);
            chk("vec_res_id",  {30'b0, res_id}, {30'b0, vecs[v].idx});
            chk("vec_res",     res,             vecs[v].exp_p);
            tick;
        end

        // ---- all four requesters from reset release: 0,1,2,3,0,1 ----
        rst_n     = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = rr_a[i];
            req_b[i] = 32'h4000_0000;
        end
        tick;
        rst_n = 1'b1;
        #1;
        chk("rr_ready_idle", {28'b0, req_ready}, 32'd0);
        tick;
        for (int g = 0; g < 6; g++) begin
            chk("rr_grant", {28'b0, req_ready}, {28'b0, 4'b0001 << (g % 4)});
            q_id.push_back(2'(g % 4));
            q_val.push_back(rr_p[g % 4]);
            tick;
        end
        req_valid = 4'h0;
        chk("rr_in_flight", {29'b0, in_flight}, 32'd6);
        collect("rr");

        // ---- 4'b1010 with rr_ptr=1: grants 3,1,3,1 ----
        req_valid = 4'b0010;
        req_a[1]  = 32'h3F00_0000;
        req_b[1]  = 32'h3F00_0000;
        q_id.push_back(2'd1);
        q_val.push_back(32'h3E80_0000);
        tick;
        req_valid = 4'b1010;
        req_a[3]  = 32'hBFA0_0000;
        req_b[3]  = 32'h4080_0000;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("alt_grant", {28'b0, req_ready}, {28'b0, alt[g]});
            q_id.push_back(alt[g][3] ? 2'd3 : 2'd1);
            q_val.push_back(alt[g][3] ? 32'hC0A0_0000 : 32'h3E80_0000);
            tick;
        end
        req_valid = 4'h0;
        collect("alt");

        // ---- drain: 3 in flight, enable dropped ----
        req_valid = 4'b0001;
        req_a[0]  = 32'h4040_0000;
        req_b[0]  = 32'h4040_0000;
        tick;
        tick;
        tick;
        enable = 1'b0;
        #1;
        chk("drain_ready_now",  {28'b0, req_ready}, 32'd0);
        chk("drain_in_flight",  {29'b0, in_flight}, 32'd3);
        tick;
        chk("drain_ready_held", {28'b0, req_ready}, 32'd0);
        chk("drain_not_idle",   {31'b0, idle},      32'd0);
        cnt        = 0;
        last_at    = -1;
        first_idle = -1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (res_valid) begin
                cnt++;
                last_at = k;
                chk("drain_res", res, 32'h4110_0000);
            end
            if (idle && first_idle < 0) first_idle = k;
        end
        req_valid = 4'h0;
        chk("drain_count",     cnt,                32'd3);
        chk("drain_idle_time", first_idle,         last_at + 1);
        chk("drain_in_flight0", {29'b0, in_flight}, 32'd0);

        // ---- async reset with 5 in flight ----
        enable    = 1'b1;
        req_valid = 4'b0001;
        req_a[0]  = 32'h3FC0_0000;
        req_b[0]  = 32'h4000_0000;
        tick;
        repeat (5) tick;
        req_valid = 4'h0;
        chk("mid_in_flight", {29'b0, in_flight}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_flight", {29'b0, in_flight}, 32'd0);
        chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("mid_rst_idle",      {31'b0, idle},      32'd1);
        tick;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (res_valid) cnt++;
        end
        chk("mid_no_results", cnt, 32'd0);

`ifdef MULT_ARB_PERF_EN
        // ---- performance counters: 6 transfers on requester 2 ----
        req_valid = 4'b0100;
        req_a[2]  = 32'h3F80_0000;
        req_b[2]  = 32'h3F80_0000;
        repeat (6) tick;
        req_valid = 4'h0;
        repeat (15) tick;
        chk("perf_grant0", grant_cnt[0], 32'd0);
        chk("perf_grant1", grant_cnt[1], 32'd0);
        chk("perf_grant2", grant_cnt[2], 32'd6);
        chk("perf_grant3", grant_cnt[3], 32'd0);
        chk("perf_busy",   busy_cnt,     32'd12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
